// File: rtl/rst_sequencer.sv
// Reset sequencer: synchronizes and filters async reset requests, holds the subsystem
// resets for a minimum time, then releases them in a staggered order and records the cause.
module rst_sequencer #(
   parameter int unsigned NUM_REQ     = 2,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FILTER_CYC  = 4,
   parameter int unsigned HOLD_CYC    = 16,
   parameter int unsigned NUM_STAGES  = 3,
   parameter int unsigned STAGE_GAP   = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_REQ-1:0]    req_n,
   input  logic                  cause_clr,
   output logic [NUM_STAGES-1:0] stage_rst_n,
   output logic                  all_released,
   output logic [NUM_REQ-1:0]    cause
);

   localparam int unsigned FILT_W = $clog2(FILTER_CYC + 1);
   localparam int unsigned HOLD_W = $clog2(HOLD_CYC + 1);
   localparam int unsigned GAP_W  = $clog2(STAGE_GAP + 1);
   localparam int unsigned IDX_W  = $clog2(NUM_STAGES + 1);

   localparam logic [1:0] S_HOLD    = 2'd0;
   localparam logic [1:0] S_RELEASE = 2'd1;
   localparam logic [1:0] S_RUN     = 2'd2;

   logic [SYNC_STAGES-1:0][NUM_REQ-1:0] r_sync;
   logic [NUM_REQ-1:0][FILT_W-1:0]      r_filt;
   logic [NUM_REQ-1:0]                  w_sync;
   logic [NUM_REQ-1:0]                  w_act;
   logic                                w_any_act;

   logic [1:0]            r_state,  w_state_nxt;
   logic [HOLD_W-1:0]     r_hold,   w_hold_nxt;
   logic [GAP_W-1:0]      r_gap,    w_gap_nxt;
   logic [IDX_W-1:0]      r_idx,    w_idx_nxt;
   logic [NUM_STAGES-1:0] r_stage,  w_stage_nxt;
   logic                  r_allrel, w_allrel_nxt;
   logic [NUM_REQ-1:0]    r_cause,  w_cause_nxt;

   assign w_sync = r_sync[SYNC_STAGES-1];

   // Synchronizer chain and per-request glitch filter
   always_ff @(negedge clk) begin
      if (!rst_n) begin
         r_sync <= '1;
         r_filt <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], req_n};
         for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (w_sync[i])
               r_filt[i] <= '0;
            else if (r_filt[i] != FILT_W'(FILTER_CYC))
               r_filt[i] <= r_filt[i] + FILT_W'(1);
         end
      end
   end

   always_comb begin
      for (int i = 0; i < int'(NUM_REQ); i++)
         w_act[i] = (r_filt[i] == FILT_W'(FILTER_CYC));
   end
   assign w_any_act = |w_act;

   always_ff @(negedge clk) begin
      if (!rst_n) begin
         r_state  <= S_HOLD;
         r_hold   <= '0;
         r_gap    <= '0;
         r_idx    <= '0;
         r_stage  <= '0;
         r_allrel <= 1'b0;
         r_cause  <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_hold   <= w_hold_nxt;
         r_gap    <= w_gap_nxt;
         r_idx    <= w_idx_nxt;
         r_stage  <= w_stage_nxt;
         r_allrel <= w_allrel_nxt;
         r_cause  <= w_cause_nxt;
      end
   end

   // Next state; an active request overrides every other transition
   always_comb begin
      w_state_nxt  = r_state;
      w_hold_nxt   = r_hold;
      w_gap_nxt    = r_gap;
      w_idx_nxt    = r_idx;
      w_stage_nxt  = r_stage;
      w_allrel_nxt = r_allrel;
      // Newly active bits win over a simultaneous clear
      w_cause_nxt  = (r_cause & ~{NUM_REQ{cause_clr}}) | w_act;

      if (w_any_act) begin
         w_state_nxt  = S_HOLD;
         w_hold_nxt   = '0;
         w_gap_nxt    = '0;
         w_idx_nxt    = '0;
         w_stage_nxt  = '0;
         w_allrel_nxt = 1'b0;
      end else begin
         case (r_state)
            S_HOLD: begin
               w_stage_nxt  = '0;
               w_allrel_nxt = 1'b0;
               if (r_hold == HOLD_W'(HOLD_CYC - 1)) begin
                  w_hold_nxt  = '0;
                  w_gap_nxt   = '0;
                  w_idx_nxt   = '0;
                  w_stage_nxt = NUM_STAGES'(1);
                  if (NUM_STAGES == 1) begin
                     w_state_nxt  = S_RUN;
                     w_allrel_nxt = 1'b1;
                  end else begin
                     w_state_nxt = S_RELEASE;
                  end
               end else begin
                  w_hold_nxt = r_hold + HOLD_W'(1);
               end
            end
            S_RELEASE: begin
               if (r_gap == GAP_W'(STAGE_GAP - 1)) begin
                  w_gap_nxt   = '0;
                  w_idx_nxt   = r_idx + IDX_W'(1);
                  w_stage_nxt = (r_stage << 1) | NUM_STAGES'(1);
                  if (r_idx + IDX_W'(1) == IDX_W'(NUM_STAGES - 1)) begin
                     w_state_nxt  = S_RUN;
                     w_allrel_nxt = 1'b1;
                  end
               end else begin
                  w_gap_nxt = r_gap + GAP_W'(1);
               end
            end
            S_RUN: ;
            default: begin
               w_state_nxt  = S_HOLD;
               w_hold_nxt   = '0;
               w_stage_nxt  = '0;
               w_allrel_nxt = 1'b0;
            end
         endcase
      end
   end

   assign stage_rst_n  = r_stage;
   assign all_released = r_allrel;
   assign cause        = r_cause;

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed bench for rst_sequencer: default-parameter instance driven from a vector
// table plus hand sequences, and a single-stage, HOLD_CYC=1 instance.
module tb_rst_sequencer;

   logic       clk = 1'b1;
   logic       rst_n;
   logic [1:0] req_n;
   logic       cause_clr;
   logic [2:0] stage_rst_n;
   logic       all_released;
   logic [1:0] cause;

   logic       rst2_n;
   logic [1:0] req2_n;
   logic [0:0] stage2_rst_n;
   logic       all2_released;
   logic [1:0] cause2;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   rst_sequencer dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_n        (req_n),
      .cause_clr    (cause_clr),
      .stage_rst_n  (stage_rst_n),
      .all_released (all_released),
      .cause        (cause)
   );

   rst_sequencer #(.NUM_STAGES(1), .HOLD_CYC(1)) dut2 (
      .clk          (clk),
      .rst_n        (rst2_n),
      .req_n        (req2_n),
      .cause_clr    (1'b0),
      .stage_rst_n  (stage2_rst_n),
      .all_released (all2_released),
      .cause        (cause2)
   );

   typedef struct {
      logic [1:0] req;
      logic       clr;
      int         n;
      logic [2:0] stage;
      logic       allr;
      logic [1:0] cse;
      string      name;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic [1:0] req, input logic clr, input int n,
                      input logic [2:0] stage, input logic allr, input logic [1:0] cse,
                      input string name);
      vec_t v;
      v.req = req; v.clr = clr; v.n = n;
      v.stage = stage; v.allr = allr; v.cse = cse; v.name = name;
      vecs.push_back(v);
   endtask

   // Advance n falling edges, then settle just past the last one
   task automatic step(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [2:0] es, input logic ea,
                        input logic [1:0] ec);
      tests++;
      if (stage_rst_n !== es || all_released !== ea || cause !== ec) begin
         fails++;
         $display("FAIL %s: stage=%b all=%b cause=%b, expected stage=%b all=%b cause=%b",
                  name, stage_rst_n, all_released, cause, es, ea, ec);
      end
   endtask

   task automatic check2(input string name, input logic es, input logic ea);
      tests++;
      if (stage2_rst_n !== es || all2_released !== ea) begin
         fails++;
         $display("FAIL %s: stage=%b all=%b, expected stage=%b all=%b",
                  name, stage2_rst_n, all2_released, es, ea);
      end
   endtask

   initial begin
      // Edge counts below are relative to the edge after which the inputs change
      add(2'b11, 0, 15, 3'b000, 0, 2'b00, "boot_e15");
      add(2'b11, 0, 1,  3'b001, 0, 2'b00, "boot_e16");
      add(2'b11, 0, 7,  3'b001, 0, 2'b00, "boot_e23");
      add(2'b11, 0, 1,  3'b011, 0, 2'b00, "boot_e24");
      add(2'b11, 0, 7,  3'b011, 0, 2'b00, "boot_e31");
      add(2'b11, 0, 1,  3'b111, 1, 2'b00, "boot_e32");
      for (int k = 0; k < 3; k++) begin
         add(2'b10, 0, 3, 3'b111, 1, 2'b00, "glitch_low");
         add(2'b11, 0, 1, 3'b111, 1, 2'b00, "glitch_gap");
      end
      add(2'b11, 0, 4,  3'b111, 1, 2'b00, "glitch_flush");
      add(2'b01, 0, 6,  3'b111, 1, 2'b00, "req1_e6");
      add(2'b01, 0, 1,  3'b000, 0, 2'b10, "req1_e7");
      add(2'b01, 0, 3,  3'b000, 0, 2'b10, "req1_e10");
      add(2'b11, 0, 18, 3'b000, 0, 2'b10, "req1_hold_e28");
      add(2'b11, 0, 1,  3'b001, 0, 2'b10, "req1_rel0_e29");
      add(2'b01, 0, 6,  3'b001, 0, 2'b10, "mid_e6");
      add(2'b01, 0, 1,  3'b000, 0, 2'b10, "mid_e7");
      add(2'b11, 0, 1,  3'b000, 0, 2'b10, "mid_no_early_e8");
      add(2'b11, 0, 17, 3'b000, 0, 2'b10, "mid_hold_e25");
      add(2'b11, 0, 1,  3'b001, 0, 2'b10, "mid_rel0_e26");
      add(2'b11, 0, 7,  3'b001, 0, 2'b10, "mid_e33");
      add(2'b11, 0, 1,  3'b011, 0, 2'b10, "mid_rel1_e34");
      add(2'b11, 0, 7,  3'b011, 0, 2'b10, "mid_e41");
      add(2'b11, 0, 1,  3'b111, 1, 2'b10, "mid_rel2_e42");
      add(2'b10, 0, 6,  3'b111, 1, 2'b10, "clr_e6");
      add(2'b10, 1, 1,  3'b000, 0, 2'b01, "clr_set_wins_e7");
      add(2'b10, 0, 1,  3'b000, 0, 2'b01, "clr_e8");
      add(2'b11, 0, 40, 3'b111, 1, 2'b01, "clr_rerun_e48");
      add(2'b11, 1, 1,  3'b111, 1, 2'b00, "clr_alone");

      rst_n = 1'b0; rst2_n = 1'b0;
      req_n = 2'b11; req2_n = 2'b11; cause_clr = 1'b0;
      step(1);
      check("in_reset_e1", 3'b000, 0, 2'b00);
      step(2);
      check("in_reset_e3", 3'b000, 0, 2'b00);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         req_n     = vecs[i].req;
         cause_clr = vecs[i].clr;
         step(vecs[i].n);
         check(vecs[i].name, vecs[i].stage, vecs[i].allr, vecs[i].cse);
      end
      cause_clr = 1'b0;
      req_n     = 2'b11;

      // Reset mid-RELEASE aborts and restarts the full hold time
      rst_n = 1'b0;
      step(1);
      check("rst_again", 3'b000, 0, 2'b00);
      rst_n = 1'b1;
      step(16);
      check("abort_setup_rel0", 3'b001, 0, 2'b00);
      step(3);
      rst_n = 1'b0;
      step(1);
      check("abort_in_release", 3'b000, 0, 2'b00);
      rst_n = 1'b1;
      step(15);
      check("abort_restart_e15", 3'b000, 0, 2'b00);
      step(1);
      check("abort_restart_e16", 3'b001, 0, 2'b00);

      // Single stage, HOLD_CYC=1: release and all_released together on edge 1
      rst2_n = 1'b0;
      step(2);
      check2("one_stage_reset", 1'b0, 1'b0);
      rst2_n = 1'b1;
      step(1);
      check2("one_stage_e1", 1'b1, 1'b1);
      req2_n = 2'b10;
      step(6);
      check2("one_stage_req_e6", 1'b1, 1'b1);
      step(1);
      check2("one_stage_req_e7", 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
